// File: rtl/rft_pkg.sv
// Shared widths and FSM state encoding for the RFT spectrum streamer.
// RFT_STREAMER_ENERGY_BEAT_EN adds the ENERGY state for the trailing energy beat.
package rft_pkg;
    localparam int N_VERT   = 8;
    localparam int AMP_W    = 16;
    localparam int PHASE_W  = 16;
    localparam int ENERGY_W = 32;
    localparam int BIN_W    = 3;
    localparam int IDX_W    = 4;
`ifdef RFT_STREAMER_ENERGY_BEAT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_STREAM, ST_ENERGY} streamer_state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_STREAM} streamer_state_t;
`endif
endpackage

// File: rtl/rft_spectrum_streamer_if.sv
// Output beat stream: valid/ready handshake, data word, beat index, end-of-frame marker.
// Master holds data/index/last stable while valid is high and ready is low.
interface rft_spectrum_streamer_if;
    import rft_pkg::*;
    logic                       m_valid;
    logic                       m_ready;
    logic [AMP_W+PHASE_W-1:0]   m_data;
    logic [IDX_W-1:0]           m_index;
    logic                       m_last;

    modport master (output m_valid, m_data, m_index, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_index, m_last, output m_ready);
endinterface

// File: rtl/rft_peak_tracker.sv
// Sequential argmax over one bin per fed cycle; result published the cycle after the last bin.
// No backpressure: fed every SCAN cycle, strict > keeps the lowest index on ties.
module rft_peak_tracker
    import rft_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             feed,
    input  logic [BIN_W-1:0] bin_idx,
    input  logic [AMP_W-1:0] amp,
    output logic [BIN_W-1:0] dominant_bin,
    output logic [AMP_W-1:0] dominant_amp,
    output logic             done
);
    logic [BIN_W-1:0] best_bin;
    logic [AMP_W-1:0] best_amp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            best_bin     <= '0;
            best_amp     <= '0;
            dominant_bin <= '0;
            dominant_amp <= '0;
            done         <= 1'b0;
        end else begin
            done <= feed && (bin_idx == BIN_W'(N_VERT - 1));
            if (feed && (start || (amp > best_amp))) begin
                best_amp <= amp;
                best_bin <= bin_idx;
            end
            // Published values hold until the next scan finishes.
            if (done) begin
                dominant_bin <= best_bin;
                dominant_amp <= best_amp;
            end
        end
    end
endmodule

// File: rtl/rft_spectrum_streamer.sv
// Captures an RFT result on a transform_valid rise, scans for the peak bin, streams 8 beats (9 with RFT_STREAMER_ENERGY_BEAT_EN).
// First beat 9 cycles after capture; beats advance only on m_valid&&m_ready; frames arriving while busy are dropped and flagged.
module rft_spectrum_streamer
    import rft_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       transform_valid,
    input  logic [AMP_W-1:0]           vertex_amplitudes [0:N_VERT-1],
    input  logic signed [PHASE_W-1:0]  vertex_phases     [0:N_VERT-1],
    input  logic [ENERGY_W-1:0]        resonance_energy,
    rft_spectrum_streamer_if.master    m,
    output logic [BIN_W-1:0]           dominant_bin,
    output logic [AMP_W-1:0]           dominant_amp,
    output logic                       busy,
    output logic                       overrun,
    input  logic                       clear_overrun
);
    streamer_state_t            state;
    logic                       tv_q;
    logic                       armed;
    logic [IDX_W-1:0]           scan_cnt;
    logic [AMP_W-1:0]           amp_q [0:N_VERT-1];
    logic signed [PHASE_W-1:0]  ph_q  [0:N_VERT-1];
    logic                       rise, final_hs, capture, scan_feed, scan_done;
    logic [BIN_W-1:0]           nxt_bin;

`ifdef RFT_STREAMER_ENERGY_BEAT_EN
    logic [ENERGY_W-1:0]        energy_q;
`else
    logic                       unused_energy;
    assign unused_energy = ^resonance_energy;
`endif

    // armed blocks a level still high out of reset from looking like a fresh rise.
    assign rise      = transform_valid && !tv_q && armed;
    assign final_hs  = m.m_valid && m.m_ready && m.m_last;
    assign capture   = rise && ((state == ST_IDLE) || final_hs);
    assign scan_feed = (state == ST_SCAN) && !scan_cnt[IDX_W-1];
    assign nxt_bin   = m.m_index[BIN_W-1:0] + 3'd1;
    assign busy      = (state != ST_IDLE);

    rft_peak_tracker u_peak (
        .clk          (clk),
        .reset        (reset),
        .start        (scan_feed && (scan_cnt == '0)),
        .feed         (scan_feed),
        .bin_idx      (scan_cnt[BIN_W-1:0]),
        .amp          (amp_q[scan_cnt[BIN_W-1:0]]),
        .dominant_bin (dominant_bin),
        .dominant_amp (dominant_amp),
        .done         (scan_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            tv_q      <= 1'b0;
            armed     <= 1'b0;
            scan_cnt  <= '0;
            overrun   <= 1'b0;
            m.m_valid <= 1'b0;
            m.m_data  <= '0;
            m.m_index <= '0;
            m.m_last  <= 1'b0;
            for (int i = 0; i < N_VERT; i++) begin
                amp_q[i] <= '0;
                ph_q[i]  <= '0;
            end
`ifdef RFT_STREAMER_ENERGY_BEAT_EN
            energy_q  <= '0;
`endif
        end else begin
            tv_q  <= transform_valid;
            armed <= armed || !transform_valid;
            if (rise && !capture)
                overrun <= 1'b1;
            else if (clear_overrun)
                overrun <= 1'b0;

            if (capture) begin
                for (int i = 0; i < N_VERT; i++) begin
                    amp_q[i] <= vertex_amplitudes[i];
                    ph_q[i]  <= vertex_phases[i];
                end
`ifdef RFT_STREAMER_ENERGY_BEAT_EN
                energy_q  <= resonance_energy;
`endif
                state     <= ST_SCAN;
                scan_cnt  <= '0;
                m.m_valid <= 1'b0;
                m.m_last  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_SCAN: begin
                        if (scan_feed)
                            scan_cnt <= scan_cnt + 4'd1;
                        if (scan_done) begin
                            state     <= ST_STREAM;
                            m.m_valid <= 1'b1;
                            m.m_index <= '0;
                            m.m_data  <= {amp_q[0], ph_q[0]};
                            m.m_last  <= 1'b0;
                        end
                    end
                    ST_STREAM: begin
                        if (m.m_valid && m.m_ready) begin
                            if (m.m_index == IDX_W'(N_VERT - 1)) begin
`ifdef RFT_STREAMER_ENERGY_BEAT_EN
                                state     <= ST_ENERGY;
                                m.m_index <= IDX_W'(N_VERT);
                                m.m_data  <= energy_q;
                                m.m_last  <= 1'b1;
`else
                                state     <= ST_IDLE;
                                m.m_valid <= 1'b0;
                                m.m_last  <= 1'b0;
`endif
                            end else begin
                                m.m_index <= {1'b0, nxt_bin};
                                m.m_data  <= {amp_q[nxt_bin], ph_q[nxt_bin]};
`ifdef RFT_STREAMER_ENERGY_BEAT_EN
                                m.m_last  <= 1'b0;
`else
                                m.m_last  <= (nxt_bin == BIN_W'(N_VERT - 1));
`endif
                            end
                        end
                    end
`ifdef RFT_STREAMER_ENERGY_BEAT_EN
                    ST_ENERGY: begin
                        if (m.m_valid && m.m_ready) begin
                            state     <= ST_IDLE;
                            m.m_valid <= 1'b0;
                            m.m_last  <= 1'b0;
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rft_spectrum_streamer.sv
// Directed bench for rft_spectrum_streamer with a frame-level reference model checked every cycle.
// Covers latency, stalls, overrun, coincident recapture and mid-frame reset.
module tb_rft_spectrum_streamer;
    import rft_pkg::*;

`ifdef RFT_STREAMER_ENERGY_BEAT_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              transform_valid;
    logic [15:0]       amps [0:7];
    logic signed [15:0] phs [0:7];
    logic [31:0]       energy;
    logic [2:0]        dom_bin;
    logic [15:0]       dom_amp;
    logic              busy, overrun, clear_overrun;
    int                cyc = 0;
    int                tests = 0, fails = 0;
    int                hs_count = 0;

    rft_spectrum_streamer_if sif ();

    rft_spectrum_streamer dut (
        .clk               (clk),
        .reset             (reset),
        .transform_valid   (transform_valid),
        .vertex_amplitudes (amps),
        .vertex_phases     (phs),
        .resonance_energy  (energy),
        .m                 (sif),
        .dominant_bin      (dom_bin),
        .dominant_amp      (dom_amp),
        .busy              (busy),
        .overrun           (overrun),
        .clear_overrun     (clear_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: wait for beat idx; mode 1: wait for last beat; mode 2: wait for idle
    task automatic wait_for(input int mode, input int idx, input int max, input string nm);
        int  n = 0;
        bit  hit;
        forever begin
            case (mode)
                0:       hit = sif.m_valid && (sif.m_index == 4'(idx));
                1:       hit = sif.m_valid && sif.m_last;
                default: hit = !busy;
            endcase
            if (hit || n >= max) break;
            step(1);
            n++;
        end
        chk({nm, "_in_time"}, 64'(hit), 64'd1);
    endtask

    // ---------------- frame-level reference model ----------------
    bit          m_busy, m_prev, m_armed, m_ovr, m_dom_pend;
    int          m_valid_at, m_pos;
    logic [31:0] m_beats [0:8];
    logic [2:0]  m_dom_bin, m_nbin;
    logic [15:0] m_dom_amp, m_namp;

    always @(negedge clk) begin
        bit exp_v, hs, fin, was_busy, rise, cap;
        if (reset) begin
            chk("rst_valid", 64'(sif.m_valid), 0);
            chk("rst_busy", 64'(busy), 0);
            chk("rst_overrun", 64'(overrun), 0);
            chk("rst_dom", {dom_bin, dom_amp}, 0);
            m_busy = 0; m_prev = 0; m_armed = 0; m_ovr = 0; m_dom_pend = 0;
            m_dom_bin = 0; m_dom_amp = 0; m_pos = 0;
        end else begin
            if (m_dom_pend && cyc >= m_valid_at) begin
                m_dom_bin = m_nbin; m_dom_amp = m_namp; m_dom_pend = 0;
            end
            exp_v = m_busy && (cyc >= m_valid_at);
            chk("m_valid", 64'(sif.m_valid), 64'(exp_v));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("overrun", 64'(overrun), 64'(m_ovr));
            chk("dominant_bin", 64'(dom_bin), 64'(m_dom_bin));
            chk("dominant_amp", 64'(dom_amp), 64'(m_dom_amp));
            if (exp_v && sif.m_valid) begin
                chk("m_data", 64'(sif.m_data), 64'(m_beats[m_pos]));
                chk("m_index", 64'(sif.m_index), 64'(m_pos));
                chk("m_last", 64'(sif.m_last), 64'(m_pos == NB - 1));
            end
            if (sif.m_valid && sif.m_ready) hs_count++;
            // what the next rising edge does
            hs = exp_v && sif.m_ready;
            fin = hs && (m_pos == NB - 1);
            was_busy = m_busy;
            if (hs) m_pos++;
            if (fin) m_busy = 0;
            rise = transform_valid && !m_prev && m_armed;
            cap = rise && (!was_busy || fin);
            if (cap) begin
                m_busy = 1; m_pos = 0; m_valid_at = cyc + 10;
                for (int i = 0; i < 8; i++) m_beats[i] = {amps[i], phs[i]};
                m_beats[8] = energy;
                m_nbin = 0;
                for (int i = 1; i < 8; i++) if (amps[i] > amps[m_nbin]) m_nbin = 3'(i);
                m_namp = amps[m_nbin];
                m_dom_pend = 1;
            end
            if (rise && !cap) m_ovr = 1;
            else if (clear_overrun) m_ovr = 0;
            m_prev = transform_valid;
            m_armed = m_armed || !transform_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, h0;
        reset = 1; transform_valid = 0; clear_overrun = 0; sif.m_ready = 0;
        energy = 32'h0001_2345;
        for (int i = 0; i < 8; i++) begin amps[i] = '0; phs[i] = 16'shF000 + 16'(i); end
        step(3);
        chk("reset_m_valid", 64'(sif.m_valid), 0);
        chk("reset_m_data", 64'(sif.m_data), 0);
        reset = 0;
        step(2);

        // A: ascending amplitudes, ready held high
        for (int i = 0; i < 8; i++) amps[i] = 16'(100 * (i + 1));
        sif.m_ready = 1;
        transform_valid = 1; t0 = cyc; h0 = hs_count;
        step(1); transform_valid = 0;
        wait_for(0, 0, 30, "A_first");
        chk("A_latency", 64'(cyc - t0), 64'd10);
        chk("A_beat0", 64'(sif.m_data), 64'h0064_F000);
        wait_for(2, 0, 30, "A_idle");
        chk("A_back_to_back", 64'(cyc - t0), 64'(10 + NB));
        chk("A_beats", 64'(hs_count - h0), 64'(NB));
        chk("A_dom_bin", 64'(dom_bin), 64'd7);
        chk("A_dom_amp", 64'(dom_amp), 64'd800);

        // B: flat amplitudes, ready toggling
        for (int i = 0; i < 8; i++) amps[i] = 16'h0100;
        h0 = hs_count;
        transform_valid = 1; step(1); transform_valid = 0;
        for (int n = 0; n < 80; n++) begin
            sif.m_ready = (n % 2 == 0);
            step(1);
            if (!busy) break;
        end
        chk("B_idle", 64'(busy), 0);
        chk("B_beats", 64'(hs_count - h0), 64'(NB));
        chk("B_dom_bin", 64'(dom_bin), 64'd0);
        chk("B_dom_amp", 64'(dom_amp), 64'h0100);

        // C: second rise during beat 3 -> overrun, frame unaltered; tie resolves low
        amps = '{16'd5, 16'd9, 16'd3, 16'd9, 16'd1, 16'd0, 16'd2, 16'd4};
        sif.m_ready = 1;
        step(1);
        transform_valid = 1; step(1); transform_valid = 0;
        wait_for(0, 3, 30, "C_beat3");
        transform_valid = 1;
        step(1);
        chk("C_overrun_set", 64'(overrun), 64'd1);
        wait_for(2, 0, 30, "C_idle");
        chk("C_dom_bin", 64'(dom_bin), 64'd1);
        chk("C_dom_amp", 64'(dom_amp), 64'd9);
        clear_overrun = 1; step(1); clear_overrun = 0;
        chk("C_overrun_clr", 64'(overrun), 64'd0);

        // D: rise coincident with final handshake recaptures without overrun
        transform_valid = 0; step(2);
        for (int i = 0; i < 8; i++) amps[i] = 16'(800 - 100 * i);
        transform_valid = 1; step(1); transform_valid = 0;
        wait_for(1, 0, 40, "D_last");
        for (int i = 0; i < 8; i++) amps[i] = 16'h0007;
        amps[5] = 16'h7777;
        transform_valid = 1; t0 = cyc;
        step(1); transform_valid = 0;
        chk("D_no_overrun", 64'(overrun), 64'd0);
        chk("D_busy", 64'(busy), 64'd1);
        chk("D_valid_drop", 64'(sif.m_valid), 64'd0);
        wait_for(0, 0, 30, "D_first");
        chk("D_latency", 64'(cyc - t0), 64'd10);
        wait_for(2, 0, 30, "D_idle");
        chk("D_dom_bin", 64'(dom_bin), 64'd5);
        chk("D_dom_amp", 64'(dom_amp), 64'h7777);

        // E: reset at beat 3 with transform_valid held high
        for (int i = 0; i < 8; i++) amps[i] = 16'(i * 3 + 1);
        transform_valid = 1;
        wait_for(0, 3, 30, "E_beat3");
        reset = 1; #1;
        chk("E_valid_async", 64'(sif.m_valid), 64'd0);
        chk("E_busy_async", 64'(busy), 64'd0);
        step(2); reset = 0;
        step(5);
        chk("E_no_capture", 64'(busy), 64'd0);
        transform_valid = 0; step(1);
        transform_valid = 1; step(1);
        chk("E_recapture", 64'(busy), 64'd1);
        wait_for(2, 0, 40, "E_idle");
        chk("E_dom_bin", 64'(dom_bin), 64'd7);
        transform_valid = 0; step(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rft_spectrum_streamer.md
RFT_SPECTRUM_STREAMER -- requirements
Module: rft_spectrum_streamer

Interface
REQ-001 SHALL have no parameters; widths come from rft_pkg (N_VERT=8, AMP_W=16, PHASE_W=16, ENERGY_W=32).
REQ-002 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-003 transform_valid  in  1  engine result-valid level.
REQ-004 vertex_amplitudes  in  [15:0] x [0:7]  unsigned bin amplitudes.
REQ-005 vertex_phases  in  signed [15:0] x [0:7]  bin phases, Q1.15 of pi.
REQ-006 resonance_energy  in  32  total spectral energy.
REQ-007 m_valid  out  1  output beat valid.
REQ-008 m_ready  in  1  downstream accept.
REQ-009 m_data  out  32  {amplitude[15:0], phase[15:0]}, or energy on the energy beat.
REQ-010 m_index  out  4  beat index.
REQ-011 m_last  out  1  final beat of frame.
REQ-012 dominant_bin  out  3  argmax bin of the last completed scan.
REQ-013 dominant_amp  out  16  amplitude at dominant_bin.
REQ-014 busy  out  1  state != IDLE.
REQ-015 overrun  out  1  sticky dropped-frame flag.
REQ-016 clear_overrun  in  1  synchronous clear for overrun.

Function
REQ-017 Capture SHALL occur on the first clock edge where transform_valid=1 and its registered previous value=0, with state IDLE; all 8 amplitudes, 8 phases and the energy are registered.
REQ-018 FSM states SHALL be IDLE, SCAN, STREAM, plus ENERGY when the macro is defined; transitions: IDLE->SCAN on capture; SCAN->STREAM after 8 cycles; STREAM->IDLE (or ->ENERGY) on the bin-7 handshake; ENERGY->IDLE on its handshake.
REQ-019 SCAN SHALL examine one bin per cycle, idx 0..7, over cycles T0+1..T0+8 (T0 = capture edge); the comparison is strictly greater-than, so the lowest index wins ties; all-zero input gives bin 0, amp 0.
REQ-020 dominant_bin and dominant_amp SHALL update at the end of SCAN, be valid from T0+9, and hold until the next SCAN completes.
REQ-021 m_valid SHALL first assert at T0+9 with m_index=0.
REQ-022 A beat SHALL transfer only when m_valid&&m_ready; m_data, m_index and m_last SHALL stay stable while m_valid&&!m_ready.
REQ-023 With m_ready held high, beats SHALL issue back-to-back, one per cycle.
REQ-024 m_last SHALL be 1 only on the final beat of the frame.
REQ-025 A capture edge arriving while state != IDLE SHALL set overrun and drop the frame, with one exception: an edge coincident with the final handshake SHALL be captured and the FSM SHALL go directly to SCAN.
REQ-026 clear_overrun SHALL clear overrun next cycle; if clear and a set occur in the same cycle, the set wins.
REQ-027 m_valid SHALL drop in the cycle after the final handshake unless a new frame begins.

Reset
REQ-028 Asserting reset SHALL force, immediately and asynchronously: state=IDLE, m_valid=0, m_data=0, m_index=0, m_last=0, dominant_bin=0, dominant_amp=0, busy=0, overrun=0, edge register=0, and clear all capture registers.
REQ-029 Reset mid-frame SHALL discard the frame; after reset deasserts, a still-high transform_valid SHALL NOT trigger a capture until it falls and rises again.

Configuration
REQ-030 RFT_STREAMER_ENERGY_BEAT_EN defined: a 9th beat is appended (m_index=8, m_data=resonance_energy, m_last=1), and bin 7 has m_last=0.
REQ-031 RFT_STREAMER_ENERGY_BEAT_EN undefined: the ENERGY state is absent, the frame is 8 beats, m_last is on index 7, and resonance_energy is unused.

Structure
REQ-032 rft_pkg SHALL hold N_VERT, AMP_W, PHASE_W, ENERGY_W and the state enum typedef (streamer_state_t).
REQ-033 One sub-module, rft_peak_tracker, SHALL hold the sequential argmax (start, bin_idx, amp in -> dominant_bin, dominant_amp, done).

Verification
REQ-034 Amps 100,200,...,800 with m_ready=1 -> m_valid first at T0+9; 8 consecutive beats; m_last at index 7; dominant_bin=7, dominant_amp=800.
REQ-035 All amps 0x0100 with m_ready toggling 1,0 -> dominant_bin=0; m_data stable across every stalled cycle; 8 beats total.
REQ-036 Second transform_valid rise during STREAM beat 3 -> overrun=1; frame continues unaltered; clear_overrun pulse -> overrun=0 next cycle.
REQ-037 Rise coincident with final handshake -> no overrun; the new frame's m_valid appears 9 cycles later.
REQ-038 Reset asserted at beat 3 with transform_valid held high -> m_valid=0 immediately; no capture until transform_valid falls and rises again.
REQ-039 Macro defined, energy 0x00012345 -> 9 beats; beat 8 m_data=0x00012345, m_index=8, m_last=1; beat 7 m_last=0.
